// File: rtl/div_clock_monitor.sv
// div_clock_monitor: synchronises a divided clock, emits edge pulses, measures its period and tracks lock
module div_clock_monitor #(
  parameter int EXPECTED_DIV = 8,
  parameter int TOLERANCE = 0,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             div_clk,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
  state_t state, state_n;
  logic s1, s2, s3;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0] cnt_p1;
  logic [MW-1:0] match_cnt, match_cnt_n;
  logic rise_ev, fall_ev, match, timeout, lost_n;
  assign rise_ev = s2 & ~s3;
  assign fall_ev = ~s2 & s3;
  assign cnt_p1 = {1'b0, cnt} + (CNT_W + 1)'(1);
  assign match = int'(cnt_p1) >= EXPECTED_DIV - TOLERANCE && int'(cnt_p1) <= EXPECTED_DIV + TOLERANCE;
  assign timeout = ~rise_ev && int'(cnt_p1) >= 2 * EXPECTED_DIV;
  // Synchroniser, edge pulses, saturating period counter and period capture
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      cnt <= '0;
      period <= '0;
      period_valid <= 1'b0;
    end else begin
      s1 <= div_clk;
      s2 <= s1;
      s3 <= s2;
      rise_pulse <= rise_ev;
      fall_pulse <= fall_ev;
      cnt <= rise_ev ? '0 : (&cnt ? cnt : cnt + CNT_W'(1));
      period_valid <= rise_ev && state != IDLE;
      if (rise_ev && state != IDLE) period <= cnt_p1[CNT_W-1:0];
    end
  end
  // Lock FSM state register; locked follows the next state so it rises with the completing period_valid
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state <= IDLE;
      match_cnt <= '0;
      locked <= 1'b0;
      lost <= 1'b0;
    end else begin
      state <= state_n;
      match_cnt <= match_cnt_n;
      locked <= state_n == LOCKED;
      lost <= lost_n;
    end
  end
  // Next-state logic: a rise always wins over a timeout in the same cycle
  always_comb begin
    state_n = state;
    match_cnt_n = match_cnt;
    lost_n = 1'b0;
    case (state)
      IDLE: begin
        if (rise_ev) begin
          state_n = MEASURE;
          match_cnt_n = '0;
        end
      end
      MEASURE: begin
        if (rise_ev) begin
          match_cnt_n = match ? match_cnt + MW'(1) : '0;
          if (match && match_cnt_n == MW'(LOCK_COUNT)) state_n = LOCKED;
        end else if (timeout) begin
          state_n = IDLE;
          match_cnt_n = '0;
        end
      end
      LOCKED: begin
        if (rise_ev && !match) begin
          lost_n = 1'b1;
          state_n = MEASURE;
          match_cnt_n = '0;
        end else if (timeout) begin
          lost_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_div_clock_monitor.sv
// tb_div_clock_monitor: scoreboard bench for two monitor instances (default and tolerant/narrow-counter)
module tb_div_clock_monitor;
  typedef struct packed {
    logic       pv;
    logic [7:0] per;
    logic       lk;
  } exp_t;
  logic clk_in = 1'b0;
  logic [1:0] rstn = '0;
  logic [1:0] dclk = '0;
  logic [1:0] rp, fp, pv, lk, ls;
  logic [7:0] per0;
  logic [4:0] per1;
  logic [7:0] perx [2];
  exp_t sq [2][$];
  int hi_cyc [2];
  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  assign perx[0] = per0;
  assign perx[1] = {3'b0, per1};

  div_clock_monitor u0 (
    .clk_in(clk_in), .reset(rstn[0]), .div_clk(dclk[0]),
    .rise_pulse(rp[0]), .fall_pulse(fp[0]), .period(per0),
    .period_valid(pv[0]), .locked(lk[0]), .lost(ls[0])
  );

  div_clock_monitor #(.TOLERANCE(1), .CNT_W(5)) u1 (
    .clk_in(clk_in), .reset(rstn[1]), .div_clk(dclk[1]),
    .rise_pulse(rp[1]), .fall_pulse(fp[1]), .period(per1),
    .period_valid(pv[1]), .locked(lk[1]), .lost(ls[1])
  );

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, want, $time);
    end
  endtask

  // One period: expectation for the rise it starts, then 4 high and lo low cycles
  task automatic per(input int d, input int lo, input bit epv, input int eper, input bit elk);
    sq[d].push_back(exp_t'{epv, eper[7:0], elk});
    hi_cyc[d] = cyc;
    dclk[d] = 1'b1;
    repeat (4) @(negedge clk_in);
    dclk[d] = 1'b0;
    repeat (lo) @(negedge clk_in);
  endtask

  for (genvar g = 0; g < 2; g++) begin : mon
    int lost_cnt = 0;
    int lost_gap = 0;
    int last_rise = 0;
    logic prev_lk = 1'b0;
    exp_t e;
    // Pop one expectation per rise_pulse and check edge/lost timing
    always @(negedge clk_in) begin
      if (rp[g] | fp[g]) chk("rise_fall_excl", int'(rp[g] & fp[g]), 0);
      if (rp[g]) begin
        chk("rise_expected", int'(sq[g].size() != 0), 1);
        if (sq[g].size() != 0) begin
          e = sq[g].pop_front();
          chk("rise_latency", cyc - hi_cyc[g], 3);
          chk("period_valid", int'(pv[g]), int'(e.pv));
          if (e.pv) chk("period", int'(perx[g]), int'(e.per));
          chk("locked", int'(lk[g]), int'(e.lk));
        end
        last_rise = cyc;
      end
      if (pv[g]) chk("pv_with_rise", int'(rp[g]), 1);
      if (fp[g]) chk("fall_latency", cyc - last_rise, 4);
      if (ls[g]) begin
        lost_cnt++;
        lost_gap = cyc - last_rise;
        chk("lost_on_unlock", int'({prev_lk, lk[g]}), 2);
      end
      prev_lk = lk[g];
    end
  end

  initial begin
    repeat (3) @(negedge clk_in);
    rstn[0] = 1'b1;
    repeat (2) @(negedge clk_in);
    per(0, 4, 0, 0, 0);
    repeat (3) per(0, 4, 1, 8, 0);
    repeat (6) per(0, 4, 1, 8, 1);
    per(0, 6, 1, 8, 1);
    per(0, 4, 1, 10, 0);
    repeat (3) per(0, 4, 1, 8, 0);
    per(0, 4, 1, 8, 1);
    chk("lost_after_stretch", mon[0].lost_cnt, 1);
    per(0, 24, 1, 8, 1);
    chk("timeout_lost", mon[0].lost_cnt, 2);
    chk("timeout_gap", mon[0].lost_gap, 16);
    chk("timeout_unlocked", int'(lk[0]), 0);
    per(0, 4, 0, 0, 0);
    repeat (3) per(0, 4, 1, 8, 0);
    per(0, 4, 1, 8, 1);
    sq[0].push_back(exp_t'{1'b1, 8'd8, 1'b1});
    hi_cyc[0] = cyc;
    dclk[0] = 1'b1;
    repeat (4) @(negedge clk_in);
    rstn[0] = 1'b0;
    @(negedge clk_in);
    chk("reset_outputs", int'({rp[0], fp[0], pv[0], lk[0], ls[0], per0}), 0);
    rstn[0] = 1'b1;
    sq[0].push_back(exp_t'{1'b0, 8'd0, 1'b0});
    hi_cyc[0] = cyc;
    repeat (4) @(negedge clk_in);
    dclk[0] = 1'b0;
    repeat (4) @(negedge clk_in);
    repeat (3) per(0, 4, 1, 8, 0);
    per(0, 12, 1, 8, 1);
    per(0, 4, 1, 16, 0);
    per(0, 20, 1, 8, 0);
    chk("lost_total_u0", mon[0].lost_cnt, 3);
    chk("unlocked_u0", int'(lk[0]), 0);
    rstn[1] = 1'b1;
    repeat (2) @(negedge clk_in);
    per(1, 3, 0, 0, 0);
    per(1, 5, 1, 7, 0);
    per(1, 3, 1, 9, 0);
    per(1, 5, 1, 7, 0);
    per(1, 2, 1, 9, 1);
    per(1, 4, 1, 6, 0);
    chk("lost_tolerance", mon[1].lost_cnt, 1);
    per(1, 40, 1, 8, 0);
    chk("cnt_saturated", int'(u1.cnt), 31);
    repeat (10) @(negedge clk_in);
    chk("cnt_no_wrap", int'(u1.cnt), 31);
    per(1, 4, 0, 0, 0);
    chk("lost_total_u1", mon[1].lost_cnt, 1);
    chk("queue0_drained", sq[0].size(), 0);
    chk("queue1_drained", sq[1].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/div_clock_monitor.md
Name: div_clock_monitor

Overview:
- Receive-side companion to the divided-clock generator.
- Takes a slow divided clock (div_clk), typically a pixel or sprite clock, and synchronises it into the fast clk_in domain.
- Emits single-cycle rise and fall enable pulses so downstream logic stays on clk_in.
- Measures the div_clk period in clk_in cycles, declares lock after consecutive in-tolerance periods, and flags loss of lock.

Parameters:
EXPECTED_DIV, 8, nominal div_clk period in clk_in cycles.
TOLERANCE, 0, allowed ± deviation of a measured period from EXPECTED_DIV.
LOCK_COUNT, 4, number of consecutive matching periods required to assert locked (≥1).
CNT_W, 8, width of the period counter and the period output; must satisfy 2^CNT_W − 1 ≥ 2*EXPECTED_DIV.

Ports:
clk_in  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-low reset; sampled on clk_in rising edge.
div_clk  input  1  divided clock under observation; asynchronous to clk_in sampling, so it is treated as async.
rise_pulse  output  1  one-cycle pulse per synchronised div_clk rising edge.
fall_pulse  output  1  one-cycle pulse per synchronised div_clk falling edge.
period  output  CNT_W  last measured rise-to-rise period in clk_in cycles.
period_valid  output  1  one-cycle strobe when period updates.
locked  output  1  high while in LOCKED state.
lost  output  1  one-cycle pulse on exit from LOCKED.

Behaviour:
- Reset (reset==0 at a clk_in edge):
  - Clears s1, s2, s3, the counter, match_cnt, period, and all pulse outputs to 0; locked=0; state=IDLE.
  - Reset mid-operation takes effect at the next edge regardless of state.
  - If div_clk is high at reset release, one rise event fires 2 edges later. This is legal and only moves the FSM IDLE→MEASURE.
- Synchroniser, every edge: s1<=div_clk, s2<=s1, s3<=s2. Internal rise_ev = s2&~s3; fall_ev = ~s2&s3.
- Pulses: rise_pulse<=rise_ev; fall_pulse<=fall_ev (registered).
  - If div_clk is first sampled high at edge E0, rise_pulse is high from E2 to E3. Same latency applies to falls.
  - rise_pulse and fall_pulse are never high together.
- Counter cnt (CNT_W bits):
  - cnt<=0 on rise_ev; otherwise cnt<=cnt+1, saturating at all-ones.
- Period measurement, on rise_ev when state≠IDLE:
  - period<=cnt+1 and period_valid=1 for one cycle (both registered, aligned with rise_pulse).
  - The first rise after IDLE produces no period_valid.
- match = |(cnt+1) − EXPECTED_DIV| ≤ TOLERANCE, evaluated only on rise_ev.
- timeout = (cnt+1 ≥ 2*EXPECTED_DIV) with no rise_ev this cycle. rise_ev has priority over timeout in the same cycle.
- FSM states: IDLE, MEASURE, LOCKED.
  - IDLE:
    - rise_ev → MEASURE, match_cnt<=0.
    - fall_ev and timeout are ignored.
  - MEASURE:
    - rise_ev & match: match_cnt+1. If it reaches LOCK_COUNT → LOCKED.
    - rise_ev & ~match: match_cnt<=0, stay.
    - timeout → IDLE, match_cnt<=0.
  - LOCKED:
    - rise_ev & match: stay.
    - rise_ev & ~match: lost=1, → MEASURE, match_cnt<=0. The mismatching period still updates period.
    - timeout: lost=1, → IDLE.
- locked is registered from the next state, so it rises in the same cycle as the period_valid that completes lock.
- lost is a one-cycle pulse, asserted in the cycle locked deasserts.
- Glitches on div_clk shorter than one clk_in period may produce rise/fall pulse pairs. These are counted as normal edges; no filtering.

Test Plan:
1. Reset and steady lock: release reset; drive div_clk as a clean divide-by-8 (4 high / 4 low) for 10 periods.
   - rise_pulse every 8 cycles, 3-edge latency; fall_pulse 4 cycles after each rise.
   - period_valid with period=8 from the 2nd rise on; locked asserts at the 5th rise (LOCK_COUNT=4); lost never pulses.
2. Mismatch break: after lock, stretch one period to 10 cycles.
   - period=10, lost pulses once, locked=0.
   - 4 further 8-cycle periods re-assert locked.
3. Timeout: after lock, hold div_clk low.
   - 16 cycles after the last rise_pulse, lost pulses and locked=0; FSM in IDLE.
   - The next rise produces rise_pulse but no period_valid.
4. Tolerance: TOLERANCE=1; periods alternating 7 and 9.
   - locked asserts after 4 matching periods.
   - A single 6-cycle period drops lock with lost=1.
5. Reset mid-lock: assert reset (0) for 1 cycle while locked with div_clk high.
   - Next cycle: all outputs 0, locked=0, lost=0.
   - One rise_pulse 3 cycles after release, with no period_valid.
6. Saturation and priority:
   - CNT_W=5, EXPECTED_DIV=8: div_clk idle for 40 cycles leaves cnt saturated at 31, no wrap, state IDLE.
   - Rise landing exactly on cycle 16 after the previous rise (cnt+1=16): rise wins over timeout, period=16, mismatch handled per FSM.
